// File: rtl/cordic_scheduler_pkg.sv
// Shared CORDIC scheduler types: port id, result entry and result word width.
package cordic_scheduler_pkg;

  localparam int RESULT_WIDTH = 32;

  typedef logic port_id_t;

  typedef struct packed {
    port_id_t                id;
    logic [RESULT_WIDTH-1:0] data;
  } result_entry_t;

endpackage

// File: rtl/cordic_scheduler_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count and full/empty flags.
// A push while full is accepted only when a pop happens in the same cycle,
// because the pop frees the slot before the push lands.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one non-stallable CORDIC pipeline between two requesters. Credits
// (in flight + buffered) never exceed DEPTH, so every result has a slot.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising clock edge; valid never waits for ready, and a port's
// ready never depends on that same port's valid.
module cordic_scheduler
  import cordic_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH+1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_arctan_en,
  input  logic [2*DATA_WIDTH-1:0] req_x,
  input  logic [2*DATA_WIDTH-1:0] req_y,
  input  logic [2*DATA_WIDTH-1:0] req_degree,
  output logic                    core_valid_in,
  output logic                    core_arctan_en_in,
  output logic [DATA_WIDTH-1:0]   core_x_in,
  output logic [DATA_WIDTH-1:0]   core_y_in,
  output logic [DATA_WIDTH-1:0]   core_degree_in,
  input  logic                    core_valid_out,
  input  logic [RESULT_WIDTH-1:0] core_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic [RESULT_WIDTH-1:0] rsp_data,
  output logic                    err_overflow,
  output logic                    err_spurious
);

  localparam int ENTRY_W = $bits(result_entry_t);

  logic [CNT_WIDTH-1:0] inflight;
  logic [CNT_WIDTH-1:0] fifo_cnt;
  logic [CNT_WIDTH:0]   credit_used;
  logic                 can_issue;
  logic                 rr_ptr;
  logic [1:0]           fire_vec;
  logic                 fire;
  port_id_t             win_id;
  logic                 id_empty;
  logic                 unused_id_full;
  port_id_t             id_head;
  logic                 ret_ok;
  logic                 ret_spurious;
  logic                 rsp_pop;
  logic                 res_full;
  logic                 res_empty;
  logic                 res_push;
  logic                 res_overflow;
  result_entry_t        res_in;
  result_entry_t        res_head;

  assign credit_used = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign can_issue   = credit_used < (CNT_WIDTH+1)'(DEPTH);

  // Round-robin grant: rr_ptr owns the tie; a port also wins when the other is idle.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && can_issue) begin
      req_ready[0] = !rr_ptr || !req_valid[1];
      req_ready[1] =  rr_ptr || !req_valid[0];
    end
  end

  assign fire_vec = req_valid & req_ready;
  assign fire     = |fire_vec;
  assign win_id   = fire_vec[1];

  // Pointer moves to the losing port after every accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_ptr <= 1'b0;
    else if (fire) rr_ptr <= ~win_id;
  end

  // Issue register: operands of the winner, strobe for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_valid_in     <= 1'b0;
      core_arctan_en_in <= 1'b0;
      core_x_in         <= '0;
      core_y_in         <= '0;
      core_degree_in    <= '0;
    end else begin
      core_valid_in <= fire;
      if (fire) begin
        core_arctan_en_in <= req_arctan_en[win_id];
        core_x_in         <= win_id ? req_x[2*DATA_WIDTH-1:DATA_WIDTH]      : req_x[DATA_WIDTH-1:0];
        core_y_in         <= win_id ? req_y[2*DATA_WIDTH-1:DATA_WIDTH]      : req_y[DATA_WIDTH-1:0];
        core_degree_in    <= win_id ? req_degree[2*DATA_WIDTH-1:DATA_WIDTH] : req_degree[DATA_WIDTH-1:0];
      end
    end
  end

  // Id queue occupancy is by construction the in-flight count.
  assign ret_ok       = core_valid_out && !id_empty;
  assign ret_spurious = core_valid_out &&  id_empty;

  sync_fifo #(.WIDTH(1), .DEPTH(DEPTH)) u_id_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fire),
    .push_data (win_id),
    .pop       (ret_ok),
    .pop_data  (id_head),
    .count     (inflight),
    .full      (unused_id_full),
    .empty     (id_empty)
  );

  assign rsp_pop      = rsp_valid && rsp_ready;
  assign res_push     = ret_ok && (!res_full || rsp_pop);
  assign res_overflow = ret_ok && res_full && !rsp_pop;
  assign res_in.id    = id_head;
  assign res_in.data  = core_out;

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_result_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (res_push),
    .push_data (res_in),
    .pop       (rsp_pop),
    .pop_data  (res_head),
    .count     (fifo_cnt),
    .full      (res_full),
    .empty     (res_empty)
  );

  assign rsp_valid = !res_empty;
  assign rsp_id    = rsp_valid ? res_head.id   : 1'b0;
  assign rsp_data  = rsp_valid ? res_head.data : '0;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (res_overflow) err_overflow <= 1'b1;
      if (ret_spurious) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Bench for cordic_scheduler: a behavioural pipeline (automatic or manually
// pulsed) feeds results back; a negedge monitor checks issue timing/operands
// and compares responses against an expected queue.
module tb_cordic_scheduler;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int LAT   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_arctan_en;
  logic [2*DW-1:0] req_x, req_y, req_degree;
  logic          core_valid_in, core_arctan_en_in;
  logic [DW-1:0] core_x_in, core_y_in, core_degree_in;
  logic          core_valid_out = 1'b0;
  logic [31:0]   core_out = '0;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [31:0]   rsp_data;
  logic          err_overflow, err_spurious;

  // Clock and global time limit.
  always #5 clk = ~clk;

  cordic_scheduler #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_arctan_en     (req_arctan_en),
    .req_x             (req_x),
    .req_y             (req_y),
    .req_degree        (req_degree),
    .core_valid_in     (core_valid_in),
    .core_arctan_en_in (core_arctan_en_in),
    .core_x_in         (core_x_in),
    .core_y_in         (core_y_in),
    .core_degree_in    (core_degree_in),
    .core_valid_out    (core_valid_out),
    .core_out          (core_out),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_id            (rsp_id),
    .rsp_data          (rsp_data),
    .err_overflow      (err_overflow),
    .err_spurious      (err_spurious)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];
  logic [48:0] issue_q[$];
  logic        man_id_q[$];
  int          grant_q[$];
  logic        auto_pipe = 1'b1;
  logic        man_valid = 1'b0;
  logic        man_spur  = 1'b0;
  logic [31:0] man_data  = '0;
  logic [LAT-1:0] pipe_v = '0;
  logic [31:0] pipe_d[LAT];
  logic        hs_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event with nothing expected", name);
  endtask

  // Stand-in for the CORDIC arithmetic: any fixed function of the operands.
  function automatic logic [31:0] model_result(input logic mode, input logic [15:0] x,
                                               input logic [15:0] y, input logic [15:0] d);
    return {x ^ y, d + {15'b0, mode}};
  endfunction

  // Monitor, scoreboard and pipeline model, all away from the active edge.
  always @(negedge clk) begin
    logic [48:0] iss;
    logic [32:0] e;
    logic        hs;
    if (!rst_n) begin
      hs_prev = 1'b0;
      pipe_v  = '0;
      core_valid_out = 1'b0;
      exp_q.delete();
      issue_q.delete();
      man_id_q.delete();
    end else begin
      check("core_valid_timing", core_valid_in, hs_prev);
      if (core_valid_in) begin
        if (issue_q.size() == 0) fail_now("issue_unexpected");
        else begin
          iss = issue_q.pop_front();
          check("core_operands", {core_arctan_en_in, core_x_in, core_y_in, core_degree_in}, iss);
        end
      end
      hs = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && req_ready[p]) begin
          hs = 1'b1;
          grant_q.push_back(p);
          issue_q.push_back({req_arctan_en[p], req_x[p*DW +: DW], req_y[p*DW +: DW], req_degree[p*DW +: DW]});
          if (auto_pipe)
            exp_q.push_back({1'(p), model_result(req_arctan_en[p], req_x[p*DW +: DW],
                                                 req_y[p*DW +: DW], req_degree[p*DW +: DW])});
          else
            man_id_q.push_back(1'(p));
        end
      end
      hs_prev = hs;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) fail_now("rsp_unexpected");
        else begin
          e = exp_q.pop_front();
          check("rsp_entry", {rsp_id, rsp_data}, e);
        end
      end
      for (int i = LAT-1; i > 0; i--) begin
        pipe_v[i] = pipe_v[i-1];
        pipe_d[i] = pipe_d[i-1];
      end
      pipe_v[0] = core_valid_in && auto_pipe;
      pipe_d[0] = model_result(core_arctan_en_in, core_x_in, core_y_in, core_degree_in);
      if (auto_pipe) begin
        core_valid_out = pipe_v[LAT-1];
        core_out       = pipe_d[LAT-1];
      end else begin
        core_valid_out = man_valid;
        core_out       = man_data;
        if (man_valid && !man_spur) begin
          if (man_id_q.size() == 0) fail_now("manual_result_no_id");
          else exp_q.push_back({man_id_q.pop_front(), man_data});
        end
      end
    end
  end

  // Driver: present op k on each port until accepted, within a cycle budget.
  task automatic run_ports(input int n0, input int n1, input int budget, output int a0, output int a1);
    int k[2];
    int n[2];
    k[0] = 0; k[1] = 0; n[0] = n0; n[1] = n1;
    for (int c = 0; c < budget && (k[0] < n[0] || k[1] < n[1]); c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        req_valid[p]           = (k[p] < n[p]);
        req_arctan_en[p]       = 1'((k[p] + p) % 2);
        req_x[p*DW +: DW]      = 16'(16'h1000 * (p + 1) + k[p]);
        req_y[p*DW +: DW]      = 16'(16'h0200 + k[p]);
        req_degree[p*DW +: DW] = 16'(16'h0030 + 3 * k[p] + p);
      end
      @(negedge clk);
      for (int p = 0; p < 2; p++)
        if (req_valid[p] && req_ready[p]) k[p]++;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    a0 = k[0];
    a1 = k[1];
  endtask

  // Driver: one manual pipeline result pulse, optionally with a response pop.
  task automatic inject(input logic [31:0] data, input logic with_pop, input logic spur);
    @(posedge clk); #1;
    man_valid = 1'b1;
    man_data  = data;
    man_spur  = spur;
    if (with_pop) rsp_ready = 1'b1;
    @(posedge clk); #1;
    man_valid = 1'b0;
    man_spur  = 1'b0;
    if (with_pop) rsp_ready = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int a0, a1, base;
    rst_n = 1'b0; req_valid = '0; req_arctan_en = '0;
    req_x = '0; req_y = '0; req_degree = '0; rsp_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset_core", {core_valid_in, core_arctan_en_in, core_x_in, core_y_in, core_degree_in}, 0);
    check("reset_rsp", {req_ready, rsp_valid, rsp_id, rsp_data, err_overflow, err_spurious}, 0);
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;

    // Single request from port 1, manually returned result.
    auto_pipe = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 2'b10; req_arctan_en = 2'b00;
    req_x = {16'h0100, 16'h0000}; req_y = '0; req_degree = {16'h1E00, 16'h0000};
    @(negedge clk);
    check("t1_ready_port1", req_ready[1], 1'b1);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    check("t1_core_valid", core_valid_in, 1'b1);
    check("t1_core_x", core_x_in, 16'h0100);
    check("t1_core_degree", core_degree_in, 16'h1E00);
    inject(32'h00800DDB, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_rsp_valid", rsp_valid, 1'b1);
    check("t1_rsp_data", rsp_data, 32'h00800DDB);
    wait_drain("t1_drain", 20);

    // Both ports continuously valid: grants alternate starting with port 0.
    @(posedge clk); #1 auto_pipe = 1'b1;
    base = grant_q.size();
    run_ports(4, 4, 40, a0, a1);
    check("t2_accept0", a0, 4);
    check("t2_accept1", a1, 4);
    for (int i = 0; i < 8; i++)
      if (grant_q.size() > base + i) check("t2_grant_order", grant_q[base+i], i % 2);
      else fail_now("t2_grant_missing");
    wait_drain("t2_drain", 40);

    // Credit limit: rsp_ready low, exactly DEPTH accepted.
    rsp_ready = 1'b0;
    run_ports(12, 0, 30, a0, a1);
    check("t3_accept_depth", a0, DEPTH);
    repeat (LAT + 3) @(negedge clk);
    check("t3_ready_blocked", req_ready, 2'b00);
    check("t3_no_overflow_full", err_overflow, 1'b0);
    @(posedge clk); #1 auto_pipe = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("t3_ready_after_pop", req_ready[0], 1'b1);
    run_ports(4, 0, 10, a0, a1);
    check("t3_accept_one_more", a0, 1);

    // Result arrives together with a response pop at full credit.
    inject(32'h00004444, 1'b1, 1'b0);
    @(negedge clk);
    check("t4_no_overflow", err_overflow, 1'b0);
    rsp_ready = 1'b1;
    wait_drain("t4_drain_order", 40);
    check("t4_empty", rsp_valid, 1'b0);

    // Spurious result with nothing in flight.
    inject(32'hDEAD0000, 1'b0, 1'b1);
    @(negedge clk);
    check("t5_spurious_set", err_spurious, 1'b1);
    check("t5_no_rsp", rsp_valid, 1'b0);
    repeat (3) @(negedge clk);
    check("t5_spurious_sticky", err_spurious, 1'b1);
    check("t5_no_overflow", err_overflow, 1'b0);

    // Reset with 3 in flight and 2 buffered.
    rsp_ready = 1'b0;
    run_ports(5, 0, 20, a0, a1);
    check("t6_accept5", a0, 5);
    inject(32'h11110001, 1'b0, 1'b0);
    inject(32'h11110002, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_buffered", rsp_valid, 1'b1);
    @(posedge clk); #1 req_valid = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    check("t6_reset_core", {core_valid_in, core_arctan_en_in, core_x_in, core_y_in, core_degree_in}, 0);
    check("t6_reset_rsp", {req_ready, rsp_valid, rsp_id, rsp_data, err_overflow, err_spurious}, 0);
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_port0_first", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    rsp_ready = 1'b1;
    inject(32'h22220000, 1'b0, 1'b0);
    wait_drain("t6_drain", 20);
    check("t6_no_spurious", err_spurious, 1'b0);
    inject(32'h33330000, 1'b0, 1'b1);
    @(negedge clk);
    check("t6_late_spurious", err_spurious, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
